// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, the InvSubBytes FSM encoding and
// the inverse S-box table reused by the decryption round logic.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_NBYTES  = 16;

  typedef enum logic [1:0] {
    ISB_IDLE = 2'd0,
    ISB_BUSY = 2'd1,
    ISB_DONE = 2'd2
  } isb_state_e;

  // Row r, column c holds InvSbox(16*r + c).
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] inv_sbox_lookup(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box: one byte in, InvSbox(byte) out.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] y
);

  assign y = inv_sbox_lookup(x);

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: accepts a 128-bit state, substitutes LANES bytes per
// cycle starting from byte 0 (MSB), then holds the result until taken.
module inv_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int LANES = 4
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int         NGROUPS  = AES_NBYTES / LANES;
  localparam int         GW       = LANES * AES_BYTE_W;
  localparam logic [3:0] LAST_CNT = 4'(NGROUPS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  isb_state_e                 state_r;
  isb_state_e                 state_nxt_s;
  logic [3:0]                 cnt_r;
  logic [AES_STATE_W-1:0]     buf_r;
  logic [AES_STATE_W-1:0]     buf_nxt_s;
  logic                       in_ready_r;
  logic                       out_valid_r;
  logic                       busy_r;

  logic [GW-1:0]              grp_s     [NGROUPS];
  logic [GW-1:0]              acc_s     [NGROUPS];
  logic [NGROUPS-1:0]         grp_hit_s;
  logic [GW-1:0]              sel_grp_s;
  logic [GW-1:0]              sub_grp_s;
  logic [AES_BYTE_W-1:0]      lane_in_s  [LANES];
  logic [AES_BYTE_W-1:0]      lane_out_s [LANES];

  // Group g covers bytes g*LANES .. g*LANES+LANES-1; selection is an AND-OR
  // chain on the counter so every slice index stays constant.
  for (genvar g = 0; g < NGROUPS; g++) begin : g_grp
    assign grp_s[g]     = buf_r[AES_STATE_W-1-g*GW -: GW];
    assign grp_hit_s[g] = (cnt_r == 4'(g));
    if (g == 0) begin : g_first
      assign acc_s[g] = {GW{grp_hit_s[g]}} & grp_s[g];
    end else begin : g_rest
      assign acc_s[g] = acc_s[g-1] | ({GW{grp_hit_s[g]}} & grp_s[g]);
    end
    assign buf_nxt_s[AES_STATE_W-1-g*GW -: GW] = grp_hit_s[g] ? sub_grp_s : grp_s[g];
  end

  assign sel_grp_s = acc_s[NGROUPS-1];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_in_s[l] = sel_grp_s[GW-1-l*AES_BYTE_W -: AES_BYTE_W];
    inv_sbox u_inv_sbox (
      .x (lane_in_s[l]),
      .y (lane_out_s[l])
    );
    assign sub_grp_s[GW-1-l*AES_BYTE_W -: AES_BYTE_W] = lane_out_s[l];
  end

  // Next-state decode for the IDLE/BUSY/DONE handshake sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ISB_IDLE: begin
        if (in_valid) state_nxt_s = ISB_BUSY;
        else          state_nxt_s = ISB_IDLE;
      end
      ISB_BUSY: begin
        if (cnt_r == LAST_CNT) state_nxt_s = ISB_DONE;
        else                   state_nxt_s = ISB_BUSY;
      end
      ISB_DONE: begin
        if (out_ready) state_nxt_s = ISB_IDLE;
        else           state_nxt_s = ISB_DONE;
      end
      default: state_nxt_s = ISB_IDLE;
    endcase
  end

  // State register and registered handshake flags, decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ISB_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == ISB_IDLE);
      out_valid_r <= (state_nxt_s == ISB_DONE);
      busy_r      <= (state_nxt_s == ISB_BUSY);
    end
  end

  // Buffer capture on accept and in-place group substitution while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_r <= {AES_STATE_W{1'b0}};
      cnt_r <= 4'd0;
    end else begin
      case (state_r)
        ISB_IDLE: begin
          if (in_valid) begin
            buf_r <= in_data;
            cnt_r <= 4'd0;
          end else begin
            buf_r <= buf_r;
            cnt_r <= cnt_r;
          end
        end
        ISB_BUSY: begin
          buf_r <= buf_nxt_s;
          if (cnt_r == LAST_CNT) cnt_r <= 4'd0;
          else                   cnt_r <= cnt_r + 4'd1;
        end
        default: begin
          buf_r <= buf_r;
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = buf_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Self-checking bench for inv_sub_bytes_iter: table vectors, random states
// against a GF(2^8)-derived inverse S-box model, and handshake corner cases.
module tb_inv_sub_bytes_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = 128'h0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;

  inv_sub_bytes_iter #(.LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  // Sweep instances for LANES = 1, 2, 8, 16 with the output always accepted.
  logic         sw_in_valid = 1'b0;
  logic [127:0] sw_in_data = 128'h0;
  logic         sw_out_ready = 1'b1;
  logic         sw_ir [4];
  logic         sw_ov [4];
  logic         sw_busy [4];
  logic [127:0] sw_od [4];

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int LV = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    inv_sub_bytes_iter #(.LANES(LV)) u_sw (
      .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_ir[g]), .in_data(sw_in_data),
      .out_valid(sw_ov[g]), .out_ready(sw_out_ready), .out_data(sw_od[g]), .busy(sw_busy[g])
    );
  end

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] KNOWN_IN  = 128'hD42711AEE0BF98F1B8B45DE51E415230;
  localparam logic [127:0] KNOWN_OUT = 128'h193DE3BEA0F4E22B9AC68D2AE9F84808;

  // Reference model: inverse S-box built from the field inverse and affine map.
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_model();
    logic [7:0] xb, inv, s;
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (xb != 8'h00 && gf_mul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      inv_tab[s] = xb;
    end
  endtask

  function automatic logic [127:0] ref_isb(input logic [127:0] d);
    logic [127:0] r = 128'h0;
    logic [7:0]   b;
    for (int p = 0; p < 16; p++) begin
      b = 8'(d >> (8 * (15 - p)));
      r = {r[119:0], inv_tab[b]};
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Wait (bounded) for out_valid; returns cycles counted from the accept edge.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vector(input string nm, input logic [127:0] din, input logic [127:0] exp);
    int lat;
    chk({nm, " in_ready idle"}, 128'(in_ready), 128'h1);
    in_valid = 1'b1;
    in_data  = din;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    chk({nm, " busy"}, 128'(busy), 128'h1);
    wait_out(lat);
    chk({nm, " latency"}, 128'(lat), 128'd4);
    chk({nm, " data"}, out_data, exp);
    chk({nm, " in_ready done"}, 128'(in_ready), 128'h0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " out_valid drop"}, 128'(out_valid), 128'h0);
    chk({nm, " in_ready back"}, 128'(in_ready), 128'h1);
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  vec_t vt [13];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int           lat;
    int           slat [4];
    logic [127:0] sdat [4];
    int           exp_lat [4] = '{16, 8, 2, 1};
    logic [127:0] a, b;

    build_model();

    #2 rst = 1'b1;
    #2;
    chk("reset in_ready", 128'(in_ready), 128'h1);
    chk("reset out_valid", 128'(out_valid), 128'h0);
    chk("reset out_data", out_data, 128'h0);
    chk("reset busy", 128'(busy), 128'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    vt[0] = '{KNOWN_IN, KNOWN_OUT};
    vt[1] = '{128'h0, {16{8'h52}}};
    vt[2] = '{{16{8'h63}}, 128'h0};
    vt[3] = '{{16{8'hFF}}, {16{8'h7D}}};
    vt[4] = '{128'h7C000000000000000000000000000000, 128'h01525252525252525252525252525252};
    for (int i = 5; i < 13; i++) begin
      vt[i].din  = {$urandom(), $urandom(), $urandom(), $urandom()};
      vt[i].dout = ref_isb(vt[i].din);
    end
    for (int i = 0; i < 13; i++)
      run_vector($sformatf("vec%0d", i), vt[i].din, vt[i].dout);

    // Backpressure: hold DONE ten cycles with a competing input pending.
    a = {$urandom(), $urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_valid = 1'b1;
    in_data  = a;
    @(negedge clk);
    in_data = b;
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp out_valid c%0d", i), 128'(out_valid), 128'h1);
      chk($sformatf("bp out_data c%0d", i), out_data, ref_isb(a));
      chk($sformatf("bp in_ready c%0d", i), 128'(in_ready), 128'h0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp handshake out_valid", 128'(out_valid), 128'h0);
    chk("bp not yet accepted", 128'(busy), 128'h0);
    chk("bp idle in_ready", 128'(in_ready), 128'h1);
    @(negedge clk);
    chk("bp accepted next", 128'(busy), 128'h1);
    in_valid = 1'b0;
    wait_out(lat);
    chk("bp second latency", 128'(lat), 128'd4);
    chk("bp second data", out_data, ref_isb(b));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset on the second BUSY cycle discards the partial state.
    in_valid = 1'b1;
    in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst mid-busy in_ready", 128'(in_ready), 128'h1);
    chk("rst mid-busy out_valid", 128'(out_valid), 128'h0);
    chk("rst mid-busy out_data", out_data, 128'h0);
    chk("rst mid-busy busy", 128'(busy), 128'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vector("after reset", KNOWN_IN, KNOWN_OUT);

    // Back-to-back with out_ready tied high.
    a = {$urandom(), $urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = a;
    @(negedge clk);
    in_data = b;
    wait_out(lat);
    chk("b2b first latency", 128'(lat), 128'd4);
    chk("b2b first data", out_data, ref_isb(a));
    @(negedge clk);
    chk("b2b idle gap in_ready", 128'(in_ready), 128'h1);
    chk("b2b idle gap busy", 128'(busy), 128'h0);
    @(negedge clk);
    chk("b2b second accepted", 128'(busy), 128'h1);
    in_valid = 1'b0;
    wait_out(lat);
    chk("b2b second latency", 128'(lat), 128'd4);
    chk("b2b second data", out_data, ref_isb(b));
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b end in_ready", 128'(in_ready), 128'h1);

    // LANES sweep on the known vector.
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("sweep%0d in_ready", g), 128'(sw_ir[g]), 128'h1);
      slat[g] = -1;
      sdat[g] = 128'h0;
    end
    sw_in_valid = 1'b1;
    sw_in_data  = KNOWN_IN;
    @(negedge clk);
    sw_in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++)
        if (sw_ov[g] && slat[g] < 0) begin
          slat[g] = c;
          sdat[g] = sw_od[g];
        end
    end
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("sweep%0d latency", g), 128'(slat[g]), 128'(exp_lat[g]));
      chk($sformatf("sweep%0d data", g), sdat[g], KNOWN_OUT);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
